// File: rtl/alu_issue.sv
// RV32I decode-and-issue stage: one registered entry between the register-file
// read and the ALU, with valid/ready handshakes on both sides and issue counters.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  output logic [4:0]  rd,
  output logic        reg_we,
  output logic        illegal,
  output logic [31:0] issue_cnt,
  output logic [15:0] illegal_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_A    = 4'b0111,
    OP_SHL  = 4'b1000,
    OP_SHR  = 4'b1010,
    OP_SHA  = 4'b1011,
    OP_SLT  = 4'b1100,
    OP_SLTU = 4'b1101,
    OP_B    = 4'b1111
  } aluop_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  function automatic aluop_t base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return OP_ADD;
      3'b001:  return OP_SHL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return OP_SHR;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  state_t      state, state_nxt;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_u;
  logic [31:0] d_a, d_b;
  aluop_t      d_op;
  logic        d_ill, d_wb, d_we;
  logic        accept, fire;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'h000};

  always_comb begin
    d_a   = rs1_data;
    d_b   = '0;
    d_op  = OP_A;
    d_ill = 1'b0;
    d_wb  = 1'b0;
    if (instr[1:0] != 2'b11) begin
      d_ill = 1'b1;
    end else begin
      case (opcode)
        OPC_OP: begin
          d_b  = rs2_data;
          d_wb = 1'b1;
          if (funct7 == F7_ZERO)                        d_op = base_op(funct3);
          else if (funct7 == F7_ALT && funct3 == 3'b000) d_op = OP_SUB;
          else if (funct7 == F7_ALT && funct3 == 3'b101) d_op = OP_SHA;
          else                                          d_ill = 1'b1;
        end
        OPC_OPIMM: begin
          d_wb = 1'b1;
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            d_b = {27'd0, instr[24:20]};
            if (funct7 == F7_ZERO)                        d_op = base_op(funct3);
            else if (funct7 == F7_ALT && funct3 == 3'b101) d_op = OP_SHA;
            else                                          d_ill = 1'b1;
          end else begin
            d_b  = imm_i;
            d_op = base_op(funct3);
          end
        end
        OPC_LUI: begin
          d_a  = '0;
          d_b  = imm_u;
          d_op = OP_B;
          d_wb = 1'b1;
        end
        OPC_AUIPC: begin
          d_a  = pc;
          d_b  = imm_u;
          d_op = OP_ADD;
          d_wb = 1'b1;
        end
        OPC_JAL, OPC_JALR: begin
          d_a  = pc;
          d_b  = 32'd4;
          d_op = OP_ADD;
          d_wb = 1'b1;
        end
        OPC_LOAD: begin
          d_b  = imm_i;
          d_op = OP_ADD;
          d_wb = 1'b1;
        end
        OPC_STORE: begin
          d_b  = imm_s;
          d_op = OP_ADD;
        end
        OPC_BRANCH: begin
          d_b = rs2_data;
          case (funct3)
            3'b000, 3'b001: d_op = OP_SUB;
            3'b100, 3'b101: d_op = OP_SLT;
            3'b110, 3'b111: d_op = OP_SLTU;
            default:        d_ill = 1'b1;
          endcase
        end
        default: d_ill = 1'b1;
      endcase
    end
    // every illegal form issues the same pass-through of rs1
    if (d_ill) begin
      d_a  = rs1_data;
      d_b  = '0;
      d_op = OP_A;
    end
  end

  assign d_we = d_wb && (instr[11:7] != 5'd0) && !d_ill;

  assign out_valid = (state == FULL);
  assign in_ready  = !rst && !flush && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    if (flush)       state_nxt = EMPTY;
    else if (accept) state_nxt = FULL;
    else if (fire)   state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= OP_ADD;
      rd      <= '0;
      reg_we  <= 1'b0;
      illegal <= 1'b0;
    end else if (accept) begin
      alu_a   <= d_a;
      alu_b   <= d_b;
      alu_op  <= d_op;
      rd      <= instr[11:7];
      reg_we  <= d_we;
      illegal <= d_ill;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt   <= '0;
      illegal_cnt <= '0;
    end else begin
      if (fire) issue_cnt <= issue_cnt + 32'd1;
      if (accept && d_ill && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus randomized traffic checked against
// an instruction-level reference model of the issue stage.
module tb_alu_issue;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, alu_a, alu_b, issue_cnt;
  logic [3:0]  alu_op;
  logic [4:0]  rd;
  logic        reg_we, illegal;
  logic [15:0] illegal_cnt;

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .rd(rd),
    .reg_we(reg_we), .illegal(illegal), .issue_cnt(issue_cnt),
    .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic        opnd;  // operands defined for this entry
  } ent_t;

  // ALU op by funct3 for the register/immediate arithmetic group, index = funct3
  localparam logic [7:0][3:0] F3OP = {4'h4, 4'h5, 4'hA, 4'h6, 4'hD, 4'hC, 4'h8, 4'h0};

  int          n_vec = 0;
  int          n_err = 0;
  logic        m_valid = 1'b0;
  logic        m_known = 1'b0;
  ent_t        m_ent = '0;
  logic [31:0] m_issue = '0;
  logic [15:0] m_ill = '0;
  logic        e_rdy, o_rdy;

  function automatic ent_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                      input logic [31:0] r1, input logic [31:0] r2);
    ent_t        e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ii, si, ui;
    logic        wb;
    f3 = ins[14:12];
    f7 = ins[31:25];
    ii = {{20{ins[31]}}, ins[31:20]};
    si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ui = {ins[31:12], 12'h000};
    e = '0;
    e.rd = ins[11:7];
    e.opnd = 1'b1;
    wb = 1'b0;
    if (ins[1:0] != 2'b11) e.ill = 1'b1;
    else case (ins[6:0])
      7'h33: begin
        e.a = r1; e.b = r2; wb = 1'b1;
        if (f7 == 7'h00) e.op = F3OP[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) e.op = 4'h1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'hB;
        else begin e.ill = 1'b1; e.opnd = 1'b0; end
      end
      7'h13: begin
        e.a = r1; wb = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.b = {27'd0, ins[24:20]};
          if (f7 == 7'h00) e.op = F3OP[f3];
          else if (f7 == 7'h20 && f3 == 3'd5) e.op = 4'hB;
          else begin e.ill = 1'b1; e.opnd = 1'b0; end
        end else begin
          e.b = ii; e.op = F3OP[f3];
        end
      end
      7'h37: begin e.a = 32'd0; e.b = ui; e.op = 4'hF; wb = 1'b1; end
      7'h17: begin e.a = pcv; e.b = ui; e.op = 4'h0; wb = 1'b1; end
      7'h6F, 7'h67: begin e.a = pcv; e.b = 32'd4; e.op = 4'h0; wb = 1'b1; end
      7'h03: begin e.a = r1; e.b = ii; e.op = 4'h0; wb = 1'b1; end
      7'h23: begin e.a = r1; e.b = si; e.op = 4'h0; end
      7'h63: begin
        e.a = r1; e.b = r2;
        if (f3 == 3'd0 || f3 == 3'd1) e.op = 4'h1;
        else if (f3 == 3'd4 || f3 == 3'd5) e.op = 4'hC;
        else if (f3 == 3'd6 || f3 == 3'd7) e.op = 4'hD;
        else begin e.ill = 1'b1; e.opnd = 1'b0; end
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.a = r1; e.b = 32'd0; e.op = 4'h7; end
    e.we = wb && (e.rd != 5'd0) && !e.ill;
    return e;
  endfunction

  // Apply one cycle of inputs, sample in_ready before the edge, advance the model.
  task automatic drive(input logic iv, input logic ordy, input logic fl, input logic rs,
                       input logic [31:0] ins, input logic [31:0] pcv,
                       input logic [31:0] r1, input logic [31:0] r2);
    ent_t d;
    logic acc, fr;
    @(negedge clk);
    in_valid = iv; out_ready = ordy; flush = fl; rst = rs;
    instr = ins; pc = pcv; rs1_data = r1; rs2_data = r2;
    #1;
    d = ref_decode(ins, pcv, r1, r2);
    e_rdy = !rs && !fl && (!m_valid || ordy);
    o_rdy = in_ready;
    acc = iv && e_rdy;
    fr = m_valid && ordy;
    @(posedge clk);
    if (rs) begin
      m_valid = 1'b0; m_ent = '0; m_ent.opnd = 1'b1; m_known = 1'b1;
      m_issue = '0; m_ill = '0;
    end else begin
      if (fr) m_issue = m_issue + 32'd1;
      if (acc && d.ill && m_ill != 16'hFFFF) m_ill = m_ill + 16'd1;
      if (fl) begin
        if (m_valid) m_known = 1'b0;
        m_valid = 1'b0;
      end else if (acc) begin
        m_valid = 1'b1; m_ent = d; m_known = 1'b1;
      end else if (fr) begin
        m_valid = 1'b0; m_known = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h00208133, 32'h40, 32'd5, 32'd7);
    n_vec++;
    if (o_rdy !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", o_rdy); end
    n_vec++;
    if ({out_valid, alu_a, alu_b, alu_op, rd, reg_we, illegal, issue_cnt, illegal_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got v=%b a=%h b=%h op=%h rd=%0d we=%b ill=%b ic=%h lc=%h want all 0",
               out_valid, alu_a, alu_b, alu_op, rd, reg_we, illegal, issue_cnt, illegal_cnt);
    end
  endtask

  task automatic test_add();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h00208133, 32'h0, 32'd5, 32'd7);
    n_vec++;
    if ({out_valid, alu_op, alu_a, alu_b, rd, reg_we, illegal} !==
        {1'b1, 4'h0, 32'd5, 32'd7, 5'd2, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL add: got v=%b op=%h a=%h b=%h rd=%0d we=%b ill=%b want v=1 op=0 a=5 b=7 rd=2 we=1 ill=0",
               out_valid, alu_op, alu_a, alu_b, rd, reg_we, illegal);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    n_vec++;
    if ({out_valid, issue_cnt} !== {1'b0, 32'd1}) begin
      n_err++; $display("FAIL add_drain: got v=%b ic=%h want v=0 ic=1", out_valid, issue_cnt);
    end
  endtask

  task automatic test_srai();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40415093, 32'h0, 32'h80000000, 32'h0);
    n_vec++;
    if ({alu_op, alu_a, alu_b, rd, reg_we, illegal} !== {4'hB, 32'h80000000, 32'd4, 5'd1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL srai: got op=%h a=%h b=%h rd=%0d we=%b ill=%b want op=b a=80000000 b=4 rd=1 we=1 ill=0",
               alu_op, alu_a, alu_b, rd, reg_we, illegal);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40411093, 32'h0, 32'h1234, 32'h0);
    n_vec++;
    if ({out_valid, illegal, reg_we, illegal_cnt, issue_cnt} !== {1'b1, 1'b1, 1'b0, 16'd1, 32'd1}) begin
      n_err++;
      $display("FAIL slli_alt: got v=%b ill=%b we=%b lc=%h ic=%h want v=1 ill=1 we=0 lc=1 ic=1",
               out_valid, illegal, reg_we, illegal_cnt, issue_cnt);
    end
  endtask

  task automatic test_lui_auipc();
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h12345037, 32'h0, 32'hdead, 32'h0);
    n_vec++;
    if ({alu_op, alu_a, alu_b, rd, reg_we} !== {4'hF, 32'd0, 32'h12345000, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL lui: got op=%h a=%h b=%h rd=%0d we=%b want op=f a=0 b=12345000 rd=0 we=0",
               alu_op, alu_a, alu_b, rd, reg_we);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h12345297, 32'h100, 32'hdead, 32'h0);
    n_vec++;
    if ({alu_op, alu_a, alu_b, rd, reg_we} !== {4'h0, 32'h100, 32'h12345000, 5'd5, 1'b1}) begin
      n_err++;
      $display("FAIL auipc: got op=%h a=%h b=%h rd=%0d we=%b want op=0 a=100 b=12345000 rd=5 we=1",
               alu_op, alu_a, alu_b, rd, reg_we);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00208133, 32'h0, 32'd5, 32'd7);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h40415093, 32'h0, 32'h80000000, 32'h0);
      n_vec++;
      if ({o_rdy, out_valid, alu_op, alu_a, alu_b, rd, issue_cnt} !==
          {1'b0, 1'b1, 4'h0, 32'd5, 32'd7, 5'd2, 32'd0}) begin
        n_err++;
        $display("FAIL stall[%0d]: got rdy=%b v=%b op=%h a=%h b=%h rd=%0d ic=%h want rdy=0 v=1 op=0 a=5 b=7 rd=2 ic=0",
                 i, o_rdy, out_valid, alu_op, alu_a, alu_b, rd, issue_cnt);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40415093, 32'h0, 32'h80000000, 32'h0);
    n_vec++;
    if ({o_rdy, out_valid, alu_op, alu_b, issue_cnt} !== {1'b1, 1'b1, 4'hB, 32'd4, 32'd1}) begin
      n_err++;
      $display("FAIL b2b_1: got rdy=%b v=%b op=%h b=%h ic=%h want rdy=1 v=1 op=b b=4 ic=1",
               o_rdy, out_valid, alu_op, alu_b, issue_cnt);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h12345037, 32'h0, 32'h0, 32'h0);
    n_vec++;
    if ({out_valid, alu_op, issue_cnt} !== {1'b1, 4'hF, 32'd2}) begin
      n_err++; $display("FAIL b2b_2: got v=%b op=%h ic=%h want v=1 op=f ic=2", out_valid, alu_op, issue_cnt);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    n_vec++;
    if ({out_valid, issue_cnt} !== {1'b0, 32'd3}) begin
      n_err++; $display("FAIL b2b_drain: got v=%b ic=%h want v=0 ic=3", out_valid, issue_cnt);
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    n_vec++;
    if ({o_rdy, out_valid, issue_cnt, illegal_cnt} !== {1'b0, 1'b0, 32'd0, 16'd0}) begin
      n_err++;
      $display("FAIL flush_in: got rdy=%b v=%b ic=%h lc=%h want all 0", o_rdy, out_valid, issue_cnt, illegal_cnt);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00208133, 32'h0, 32'd5, 32'd7);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    n_vec++;
    if ({out_valid, issue_cnt, illegal_cnt} !== {1'b0, 32'd0, 16'd0}) begin
      n_err++;
      $display("FAIL flush_full: got v=%b ic=%h lc=%h want v=0 ic=0 lc=0", out_valid, issue_cnt, illegal_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00208133, 32'h0, 32'd5, 32'd7);
    force dut.issue_cnt = 32'hFFFFFFFF;
    #1;
    release dut.issue_cnt;
    m_issue = 32'hFFFFFFFF;
    n_vec++;
    if (issue_cnt !== 32'hFFFFFFFF) begin
      n_err++; $display("FAIL wrap_preset: got %h want ffffffff", issue_cnt);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    n_vec++;
    if ({out_valid, issue_cnt} !== {1'b0, 32'd0}) begin
      n_err++; $display("FAIL wrap: got v=%b ic=%h want v=0 ic=0", out_valid, issue_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    force dut.illegal_cnt = 16'hFFFE;
    #1;
    release dut.illegal_cnt;
    m_ill = 16'hFFFE;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    n_vec++;
    if (illegal_cnt !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_1: got %h want ffff", illegal_cnt);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    n_vec++;
    if (illegal_cnt !== 16'hFFFF) begin
      n_err++; $display("FAIL sat_2: got %h want ffff", illegal_cnt);
    end
  endtask

  task automatic test_rst_full();
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00208133, 32'h0, 32'd5, 32'd7);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h12345297, 32'h100, 32'd1, 32'd2);
    n_vec++;
    if ({o_rdy, out_valid, alu_a, alu_b, alu_op, rd, reg_we, illegal, issue_cnt, illegal_cnt} !== '0) begin
      n_err++;
      $display("FAIL rst_full: got rdy=%b v=%b a=%h b=%h op=%h rd=%0d we=%b ill=%b ic=%h lc=%h want all 0",
               o_rdy, out_valid, alu_a, alu_b, alu_op, rd, reg_we, illegal, issue_cnt, illegal_cnt);
    end
  endtask

  task automatic test_random();
    logic [6:0]  opc;
    logic [31:0] ins;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 11))
        0, 9:    opc = 7'h33;
        1, 10:   opc = 7'h13;
        2:       opc = 7'h37;
        3:       opc = 7'h17;
        4:       opc = ($urandom_range(0, 1) == 0) ? 7'h6F : 7'h67;
        5:       opc = 7'h03;
        6:       opc = 7'h23;
        7:       opc = 7'h63;
        default: opc = 7'($urandom);
      endcase
      ins = $urandom;
      ins[6:0] = opc;
      case ($urandom_range(0, 3))
        0, 2:    ins[31:25] = 7'h00;
        1:       ins[31:25] = 7'h20;
        default: ins[31:25] = 7'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
            ins, $urandom, $urandom, $urandom);
      n_vec++;
      if (o_rdy !== e_rdy) begin
        n_err++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, o_rdy, e_rdy);
      end
      n_vec++;
      if ({out_valid, issue_cnt, illegal_cnt} !== {m_valid, m_issue, m_ill}) begin
        n_err++;
        $display("FAIL rnd_status[%0d]: got v=%b ic=%h lc=%h want v=%b ic=%h lc=%h",
                 i, out_valid, issue_cnt, illegal_cnt, m_valid, m_issue, m_ill);
      end
      if (m_known) begin
        n_vec++;
        if ({rd, reg_we, illegal} !== {m_ent.rd, m_ent.we, m_ent.ill}) begin
          n_err++;
          $display("FAIL rnd_ctrl[%0d]: got rd=%0d we=%b ill=%b want rd=%0d we=%b ill=%b",
                   i, rd, reg_we, illegal, m_ent.rd, m_ent.we, m_ent.ill);
        end
        if (m_ent.opnd) begin
          n_vec++;
          if ({alu_op, alu_a, alu_b} !== {m_ent.op, m_ent.a, m_ent.b}) begin
            n_err++;
            $display("FAIL rnd_operands[%0d]: got op=%h a=%h b=%h want op=%h a=%h b=%h",
                     i, alu_op, alu_a, alu_b, m_ent.op, m_ent.a, m_ent.b);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    test_reset();
    test_add();
    test_srai();
    test_lui_auipc();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_saturate();
    test_rst_full();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
